wb_stage: RTL
=============

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- XZR, 5'd31, zero-register index; writes to it are suppressed.
- CNT_W, 32, width of the retired-instruction counter.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on posedge.
- reset, in, 1: synchronous, active-high reset.
- stall, in, 1: hold the MEM/WB register.
- flush, in, 1: load a bubble into the MEM/WB register.
- mem_valid, in, 1: MEM-stage instruction is valid.
- mem_RegWrite, in, 1: MEM-stage instruction writes the regfile.
- mem_MemtoReg, in, 1: result is load data (1) or ALU result (0).
- mem_BLsignal, in, 1: branch-and-link; write the link value.
- mem_Rd, in, 5: destination register.
- mem_alu_result, in, 64: ALU result.
- mem_read_data, in, 64: data-memory read data.
- mem_pc_plus4, in, 64: link value for BL.
- WBsignal, out, 64: selected result (load data or ALU result) for the regfile write mux.
- BLT, out, 64: link value for the regfile write mux.
- BLsignal, out, 1: write-data mux select (1 selects BLT).
- RegWrite, out, 1: regfile write enable.
- Rd_wb, out, 5: regfile write address.
- fwd_valid, out, 1: forwarding data is live.
- fwd_Rd, out, 5: forwarding destination.
- fwd_data, out, 64: value being written back.
- retired_count, out, CNT_W: count of valid instructions captured into WB.

Function
REQ-003 The block SHALL hold one MEM/WB pipeline register containing: valid, RegWrite, BLsignal, Rd, the selected result (mem_MemtoReg ? mem_read_data : mem_alu_result), and pc_plus4.
REQ-004 Result selection SHALL happen before the register, so WBsignal is a registered value.
REQ-005 Latency SHALL be exactly one cycle: MEM inputs sampled at edge N appear on the outputs after edge N.
REQ-006 Update priority per posedge SHALL be reset > flush > stall > capture.
REQ-007 On flush, the block SHALL clear valid, RegWrite and BLsignal; the data fields are don't-care.
REQ-008 On stall without flush, the block SHALL hold all register fields unchanged; a held write re-asserts RegWrite with identical address and data, which is idempotent.
REQ-009 On capture, the block SHALL load all fields from the mem_* inputs; if mem_valid=0, valid, RegWrite and BLsignal SHALL load 0.
REQ-010 Output RegWrite SHALL equal registered valid & registered RegWrite & (Rd != XZR).
REQ-011 Output BLsignal SHALL equal registered valid & registered BLsignal.
REQ-012 Rd_wb SHALL equal the registered Rd; WBsignal and BLT SHALL equal the registered result and registered pc_plus4.
REQ-013 fwd_valid SHALL equal output RegWrite, fwd_Rd SHALL equal Rd_wb, and fwd_data SHALL equal BLsignal ? BLT : WBsignal (combinational from registers).
REQ-014 retired_count SHALL increment by 1 on each posedge that captures with mem_valid=1.
REQ-015 retired_count SHALL wrap from 2^CNT_W-1 to 0 without saturation.
REQ-016 retired_count SHALL NOT change on stall, flush or reset-cycle edges; it is the count at the output, not a pending value.
REQ-017 When stall and flush are asserted together, flush SHALL win and the instruction in WB is discarded, not counted again.

Reset
REQ-018 On a posedge with reset=1, the block SHALL clear valid, RegWrite, BLsignal, Rd, result, pc_plus4 and retired_count to 0.
REQ-019 After that reset edge, all outputs SHALL read 0, including fwd_valid=0 and fwd_data=0.
REQ-020 Reset asserted mid-stall SHALL discard the held instruction; no regfile write SHALL occur in the cycle after the reset edge.

Structure
REQ-021 XZR and the 64-bit data width constant SHALL live in the shared CPU package, with a packed struct typedef for the MEM/WB register fields.
REQ-022 The block SHALL instantiate one sub-module, pipe_reg_en_clr, a parameterised-width register with synchronous clear and enable, used for the MEM/WB register.
REQ-023 The existing mux64_2x1 SHALL be reused for the pre-register result select and for fwd_data.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- ALU op: mem_valid=1, RegWrite=1, MemtoReg=0, Rd=5, alu=64'h1234 -> next cycle RegWrite=1, Rd_wb=5, WBsignal=64'h1234, fwd_data=64'h1234, retired_count=1.
- Load: MemtoReg=1, read_data=64'hDEAD, alu=64'h8 -> WBsignal=64'hDEAD.
- BL: BLsignal=1, Rd=30, pc_plus4=64'h104 -> BLsignal=1, BLT=64'h104, fwd_data=64'h104.
- Zero register: Rd=31 with RegWrite=1 -> RegWrite=0, fwd_valid=0, retired_count still increments.
- Stall, then stall+flush: stall 3 cycles with valid ADD -> outputs and count constant; then stall=1, flush=1 -> RegWrite=0 and count unchanged.
- Wrap and reset: preload count to 32'hFFFFFFFF by capturing, capture one more -> 0; then assert reset during a stall -> all outputs 0 next cycle.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared CPU constants and the MEM/WB pipeline register layout.
package wb_stage_pkg;

    localparam int unsigned DATA_W = 64;
    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic              valid;
        logic              reg_write;
        logic              bl;
        logic [4:0]        rd;
        logic [DATA_W-1:0] result;
        logic [DATA_W-1:0] pc_plus4;
    } memwb_t;

endpackage

// File: rtl/mux64_2x1.sv
// Plain 64-bit two-input multiplexer; sel=1 picks b.
module mux64_2x1 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        sel,
    output logic [63:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/pipe_reg_en_clr.sv
// Generic pipeline register with synchronous clear (reset or flush) and load enable.
module pipe_reg_en_clr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear beats enable so a flush during a stall still drops the held entry.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, regfile write controls, forwarding and retire counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter logic [4:0]  XZR   = wb_stage_pkg::XZR_IDX,
    parameter int unsigned CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_valid,
    input  logic              mem_RegWrite,
    input  logic              mem_MemtoReg,
    input  logic              mem_BLsignal,
    input  logic [4:0]        mem_Rd,
    input  logic [DATA_W-1:0] mem_alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [DATA_W-1:0] mem_pc_plus4,
    output logic [DATA_W-1:0] WBsignal,
    output logic [DATA_W-1:0] BLT,
    output logic              BLsignal,
    output logic              RegWrite,
    output logic [4:0]        Rd_wb,
    output logic              fwd_valid,
    output logic [4:0]        fwd_Rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  retired_count
);

    memwb_t            memwb_d;
    memwb_t            memwb_q;
    logic [DATA_W-1:0] mem_result;
    logic [CNT_W-1:0]  count_q;

    mux64_2x1 u_result_mux (
        .a   (mem_alu_result),
        .b   (mem_read_data),
        .sel (mem_MemtoReg),
        .y   (mem_result)
    );

    // Control bits are qualified by mem_valid so a bubble can never write.
    always_comb begin
        memwb_d           = '0;
        memwb_d.valid     = mem_valid;
        memwb_d.reg_write = mem_valid & mem_RegWrite;
        memwb_d.bl        = mem_valid & mem_BLsignal;
        memwb_d.rd        = mem_Rd;
        memwb_d.result    = mem_result;
        memwb_d.pc_plus4  = mem_pc_plus4;
    end

    pipe_reg_en_clr #(
        .W ($bits(memwb_t))
    ) u_memwb_reg (
        .clk   (clk),
        .reset (reset),
        .clr   (flush),
        .en    (~stall),
        .d     (memwb_d),
        .q     (memwb_q)
    );

    assign RegWrite = memwb_q.valid & memwb_q.reg_write & (memwb_q.rd != XZR);
    assign BLsignal = memwb_q.valid & memwb_q.bl;
    assign Rd_wb    = memwb_q.rd;
    assign WBsignal = memwb_q.result;
    assign BLT      = memwb_q.pc_plus4;

    assign fwd_valid = RegWrite;
    assign fwd_Rd    = Rd_wb;

    mux64_2x1 u_fwd_mux (
        .a   (WBsignal),
        .b   (BLT),
        .sel (BLsignal),
        .y   (fwd_data)
    );

    // Counts only genuine captures, so held or flushed entries are never recounted.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (!flush && !stall && mem_valid) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign retired_count = count_q;

endmodule
